// File: rtl/hist_pkg.sv
// Shared constants, types and bin-extraction helper for the histogram stream-out block.
package hist_pkg;

  localparam int WORD_W   = 128;
  localparam int BIN_W    = 8;
  localparam int NUM_BINS = WORD_W / BIN_W;
  localparam int IDX_W    = $clog2(NUM_BINS);
  localparam int SUM_W    = BIN_W + IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } hist_state_t;

  typedef logic [BIN_W-1:0] bin_t;

  function automatic bin_t get_bin(input logic [WORD_W-1:0] word,
                                   input logic [IDX_W-1:0]  k);
    return word[k*BIN_W +: BIN_W];
  endfunction

endpackage

// File: rtl/hist_bin_stats.sv
// Running statistics over accepted bins: total count plus the first-occurring peak bin.
module hist_bin_stats
  import hist_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             accept,
  input  bin_t             bin_data,
  input  logic [IDX_W-1:0] bin_index,
  output logic [SUM_W-1:0] total_sum,
  output bin_t             max_value,
  output logic [IDX_W-1:0] max_index
);

  // Strict compare so equal later bins never displace an earlier peak.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      total_sum <= '0;
      max_value <= '0;
      max_index <= '0;
    end else if (accept) begin
      total_sum <= total_sum + SUM_W'(bin_data);
      if (bin_data > max_value) begin
        max_value <= bin_data;
        max_index <= bin_index;
      end
    end
  end

endmodule

// File: rtl/hist_stream_out.sv
// Snapshots a histogram word on start and streams it out one bin per valid/ready handshake.
module hist_stream_out
  import hist_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] hist_in,
  output logic              bin_valid,
  input  logic              bin_ready,
  output bin_t              bin_data,
  output logic [IDX_W-1:0]  bin_index,
  output logic              bin_last,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  total_sum,
  output bin_t              max_value,
  output logic [IDX_W-1:0]  max_index
);

  hist_state_t       state, state_nxt;
  logic [WORD_W-1:0] snap;
  logic [IDX_W-1:0]  idx;
  logic              capture;
  logic              accept;
  logic              last_bin;

  assign capture  = (state == IDLE) && start;
  assign accept   = (state == STREAM) && bin_ready;
  assign last_bin = (idx == IDX_W'(NUM_BINS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (accept && last_bin) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only; bin_ready never reaches them combinationally.
  always_comb begin
    bin_valid = (state == STREAM);
    bin_last  = (state == STREAM) && last_bin;
    busy      = (state != IDLE);
    done      = (state == DONE);
    bin_index = idx;
    bin_data  = get_bin(snap, idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap <= '0;
      idx  <= '0;
    end else if (capture) begin
      snap <= hist_in;
      idx  <= '0;
    end else if (accept && !last_bin) begin
      idx <= idx + 1'b1;
    end
  end

  hist_bin_stats u_stats (
    .clk       (clk),
    .reset     (reset),
    .clear     (capture),
    .accept    (accept),
    .bin_data  (bin_data),
    .bin_index (idx),
    .total_sum (total_sum),
    .max_value (max_value),
    .max_index (max_index)
  );

endmodule

// File: tb/tb_hist_stream_out.sv
// Scoreboard bench for hist_stream_out: driver queues expected bins/stats, monitor checks them.
module tb_hist_stream_out;

  typedef struct {
    logic [7:0] data;
    logic [3:0] idx;
    logic       last;
  } bin_exp_t;

  typedef struct {
    logic [11:0] sum;
    logic [7:0]  maxv;
    logic [3:0]  maxi;
  } stat_exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] hist_in;
  logic         bin_valid;
  logic         bin_ready;
  logic [7:0]   bin_data;
  logic [3:0]   bin_index;
  logic         bin_last;
  logic         busy;
  logic         done;
  logic [11:0]  total_sum;
  logic [7:0]   max_value;
  logic [3:0]   max_index;

  bin_exp_t  exp_bins[$];
  stat_exp_t exp_stats[$];
  stat_exp_t last_stat;

  int n_checks = 0;
  int n_pass   = 0;
  int ready_mode = 0;
  int ready_cnt  = 0;

  hist_stream_out dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .hist_in   (hist_in),
    .bin_valid (bin_valid),
    .bin_ready (bin_ready),
    .bin_data  (bin_data),
    .bin_index (bin_index),
    .bin_last  (bin_last),
    .busy      (busy),
    .done      (done),
    .total_sum (total_sum),
    .max_value (max_value),
    .max_index (max_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: bins in order, sum, peak value and its first occurrence.
  task automatic model_push(input logic [127:0] w);
    logic [7:0] b[16];
    stat_exp_t  s;
    bin_exp_t   e;
    int         first;
    s.sum  = '0;
    s.maxv = '0;
    for (int k = 0; k < 16; k++) begin
      b[k] = w[k*8 +: 8];
      s.sum += 12'(b[k]);
      if (b[k] > s.maxv) s.maxv = b[k];
    end
    first = -1;
    for (int k = 0; k < 16; k++)
      if (first < 0 && b[k] == s.maxv) first = k;
    s.maxi = 4'(first);
    for (int k = 0; k < 16; k++) begin
      e.data = b[k];
      e.idx  = 4'(k);
      e.last = (k == 15);
      exp_bins.push_back(e);
    end
    exp_stats.push_back(s);
    last_stat = s;
  endtask

  task automatic issue_start(input logic [127:0] w);
    @(posedge clk); #1;
    hist_in = w;
    start   = 1'b1;
    model_push(w);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called right after the start edge; exp_lat < 0 skips the latency compare.
  task automatic wait_done(input int exp_lat);
    int n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) chk("done timeout", 0, 1);
    else if (exp_lat >= 0) chk("done latency", n, exp_lat);
    @(posedge clk); #1;
    chk("idle busy", busy, 0);
    chk("hold sum", total_sum, last_stat.sum);
    chk("hold maxv", max_value, last_stat.maxv);
    chk("hold maxi", max_index, last_stat.maxi);
  endtask

  initial begin
    bin_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bin_ready = 1'b1;
        1:       bin_ready = 1'($urandom_range(0, 1));
        default: begin
          bin_ready = (ready_cnt % 3 == 0);
          ready_cnt++;
        end
      endcase
    end
  end

  // Monitor: handshakes pop expected bins; done pops expected statistics.
  initial begin
    logic     stalled = 1'b0;
    logic     prev_done = 1'b0;
    bin_exp_t held;
    bin_exp_t e;
    stat_exp_t s;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled   = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall valid", bin_valid, 1);
          chk("stall data", bin_data, held.data);
          chk("stall index", bin_index, held.idx);
        end
        if (bin_valid && bin_ready) begin
          if (exp_bins.size() == 0) chk("extra bin", 1, 0);
          else begin
            e = exp_bins.pop_front();
            chk("bin data", bin_data, e.data);
            chk("bin index", bin_index, e.idx);
            chk("bin last", bin_last, e.last);
          end
        end
        stalled = bin_valid && !bin_ready;
        held.data = bin_data;
        held.idx  = bin_index;
        if (done) begin
          chk("done single", prev_done, 0);
          chk("done busy", busy, 1);
          chk("done valid", bin_valid, 0);
          chk("bins left at done", exp_bins.size(), 0);
          if (exp_stats.size() == 0) chk("unexpected done", 1, 0);
          else begin
            s = exp_stats.pop_front();
            chk("total_sum", total_sum, s.sum);
            chk("max_value", max_value, s.maxv);
            chk("max_index", max_index, s.maxi);
          end
        end
        prev_done = done;
      end
    end
  end

  initial begin
    logic [127:0] w;
    logic [127:0] w2;
    reset   = 1'b1;
    start   = 1'b0;
    hist_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst valid", bin_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst last", bin_last, 0);
    chk("rst sum", total_sum, 0);
    chk("rst maxv", max_value, 0);
    chk("rst maxi", max_index, 0);
    reset = 1'b0;

    // Ascending 1..16 at full rate
    ready_mode = 0;
    for (int k = 0; k < 16; k++) w[k*8 +: 8] = 8'(k + 1);
    issue_start(w);
    wait_done(16);

    // All 0xFF: no wrap, tie keeps index 0
    w = {16{8'hFF}};
    issue_start(w);
    wait_done(16);

    // All zero
    issue_start('0);
    wait_done(16);

    // Peaks tied at bins 3 and 9
    for (int k = 0; k < 16; k++) w[k*8 +: 8] = 8'($urandom_range(0, 127));
    w[3*8 +: 8] = 8'h80;
    w[9*8 +: 8] = 8'h80;
    issue_start(w);
    wait_done(16);

    // Ready pattern 1,0,0
    ready_mode = 2;
    ready_cnt  = 0;
    issue_start(rand_word());
    wait_done(-1);

    // Start and new word during STREAM are ignored; next start takes the new word
    ready_mode = 0;
    w  = rand_word();
    w2 = rand_word();
    issue_start(w);
    repeat (4) @(posedge clk);
    #1;
    hist_in = w2;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(-1);
    issue_start(w2);
    wait_done(16);

    // Reset while bin 7 is presented
    issue_start(rand_word());
    repeat (7) @(posedge clk);
    #1;
    chk("pre-reset index", bin_index, 7);
    reset = 1'b1;
    exp_bins.delete();
    exp_stats.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort valid", bin_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sum", total_sum, 0);
    chk("abort maxv", max_value, 0);
    chk("abort maxi", max_index, 0);
    repeat (20) @(posedge clk);
    #1;
    issue_start(rand_word());
    wait_done(16);

    // Random words with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 6; i++) begin
      issue_start(rand_word());
      wait_done(-1);
    end

    repeat (3) @(posedge clk);
    chk("bins queue drained", exp_bins.size(), 0);
    chk("stats queue drained", exp_stats.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
